// File: rtl/fetch_pkg.sv
// fetch_pkg: shared counter encoding, BTB entry layout and width helpers for the fetch front end
package fetch_pkg;

    localparam int ADDR_MAX = 64;

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;

    typedef struct packed {
        logic                valid;
        logic [ADDR_MAX-1:0] tag;
        logic [ADDR_MAX-1:0] target;
        ctr_e                ctr;
    } btb_entry_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_w(input int xlen, input int depth);
        return xlen - $clog2(depth) - 2;
    endfunction

    function automatic ctr_e ctr_inc(input ctr_e c);
        return c == ST ? ST : ctr_e'(c + 2'b01);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return c == SNT ? SNT : ctr_e'(c - 2'b01);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: pipeline-control and imem-side signals of the fetch front end
interface fetch_unit_if #(parameter int XLEN = 32, parameter int CNT_W = 32);

    logic            stall_i;
    logic            id_jr_i;
    logic [XLEN-1:0] id_jr_target_i;
    logic            id_jump_i;
    logic [XLEN-1:0] id_jump_target_i;
    logic            ex_resolve_valid_i;
    logic [XLEN-1:0] ex_resolve_pc_i;
    logic            ex_taken_i;
    logic [XLEN-1:0] ex_target_i;
    logic            ex_pred_taken_i;
    logic [XLEN-1:0] ex_pred_target_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            flush_ifid_o;
    logic            flush_idex_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output stall_i, id_jr_i, id_jr_target_i, id_jump_i, id_jump_target_i,
               ex_resolve_valid_i, ex_resolve_pc_i, ex_taken_i, ex_target_i,
               ex_pred_taken_i, ex_pred_target_i,
        input  pc_o, pc_plus4_o, pred_taken_o, pred_target_o, flush_ifid_o,
               flush_idex_o, branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  stall_i, id_jr_i, id_jr_target_i, id_jump_i, id_jump_target_i,
               ex_resolve_valid_i, ex_resolve_pc_i, ex_taken_i, ex_target_i,
               ex_pred_taken_i, ex_pred_target_i,
        output pc_o, pc_plus4_o, pred_taken_o, pred_target_o, flush_ifid_o,
               flush_idex_o, branch_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/fetch_btb.sv
// fetch_btb: direct-mapped branch target buffer with 2-bit saturating direction counters
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:2] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:2] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = idx_w(BTB_DEPTH);
    localparam int TAG_W = tag_w(XLEN, BTB_DEPTH);

    btb_entry_t       mem [BTB_DEPTH];
    btb_entry_t       l_e, u_e;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             l_hit, u_hit;

    assign l_e         = mem[lookup_pc[IDX_W+1:2]];
    assign l_hit       = l_e.valid && l_e.tag == ADDR_MAX'(lookup_pc[XLEN-1:IDX_W+2]);
    assign pred_taken  = l_hit && (l_e.ctr inside {WT, ST});
    assign pred_target = l_hit ? XLEN'(l_e.target) : '0;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_W+2];
    assign u_e   = mem[u_idx];
    assign u_hit = u_e.valid && u_e.tag == ADDR_MAX'(u_tag);

    // train on resolved branches; a taken miss evicts whatever shared the index
    always_ff @(posedge clk)
        if (reset)
            for (int i = 0; i < BTB_DEPTH; i++) mem[i].valid <= 1'b0;
        else if (upd_valid && upd_taken)
            mem[u_idx] <= '{valid: 1'b1, tag: ADDR_MAX'(u_tag), target: ADDR_MAX'(upd_target),
                            ctr: u_hit ? ctr_inc(u_e.ctr) : WT};
        else if (upd_valid && u_hit)
            mem[u_idx].ctr <= ctr_dec(u_e.ctr);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, redirect arbitration, flush generation and BTB prediction (optional perf counters under FETCH_PERF_EN)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0,
    parameter int              CNT_W     = 32
) (
    input logic        clk,
    input logic        reset,
    fetch_unit_if.slave bus
);

    logic [XLEN-1:0] pc, next_pc, pred_target;
    logic            pred_taken, mp, id_redirect;

    assign mp = bus.ex_resolve_valid_i &
                ((bus.ex_taken_i != bus.ex_pred_taken_i) |
                 (bus.ex_taken_i & bus.ex_pred_taken_i & (bus.ex_target_i != bus.ex_pred_target_i)));
    assign id_redirect = (bus.id_jr_i | bus.id_jump_i) & ~bus.stall_i;

    assign bus.pc_o          = pc;
    assign bus.pc_plus4_o    = pc + XLEN'(4);
    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_target;
    assign bus.flush_ifid_o  = ~reset & (mp | id_redirect);
    assign bus.flush_idex_o  = ~reset & mp;

    // next-PC priority: EX correction, jr, j/jal, stall hold, BTB prediction, sequential
    always_comb
        next_pc = mp                            ? (bus.ex_taken_i ? bus.ex_target_i : bus.ex_resolve_pc_i + XLEN'(4)) :
                  bus.id_jr_i & ~bus.stall_i    ? bus.id_jr_target_i :
                  bus.id_jump_i & ~bus.stall_i  ? bus.id_jump_target_i :
                  bus.stall_i                   ? pc :
                  pred_taken                    ? pred_target : pc + XLEN'(4);

    // PC register
    always_ff @(posedge clk)
        if (reset) pc <= RESET_PC;
        else       pc <= next_pc;

    fetch_btb #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc[XLEN-1:2]),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bus.ex_resolve_valid_i),
        .upd_pc      (bus.ex_resolve_pc_i[XLEN-1:2]),
        .upd_taken   (bus.ex_taken_i),
        .upd_target  (bus.ex_target_i)
    );

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    // wrapping counts of resolved branches and mispredictions
    always_ff @(posedge clk)
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            branch_cnt  <= branch_cnt + CNT_W'(bus.ex_resolve_valid_i);
            mispred_cnt <= mispred_cnt + CNT_W'(mp);
        end

    assign bus.branch_cnt_o  = branch_cnt;
    assign bus.mispred_cnt_o = mispred_cnt;
`else
    assign bus.branch_cnt_o  = '0;
    assign bus.mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for PC arbitration, flushes and BTB training
module tb_fetch_unit;

    typedef struct {
        logic        stall, jr;
        logic [31:0] jrt;
        logic        jump;
        logic [31:0] jt;
        logic        rv;
        logic [31:0] rpc;
        logic        tk;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] pc;
        logic        fi, fx;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0, passed = 0, exp_br = 0, exp_mp = 0;
    vec_t tbl [13];

    fetch_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    fetch_unit #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h100), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic idle();
        bus.stall_i = 1'b0; bus.id_jr_i = 1'b0; bus.id_jr_target_i = '0;
        bus.id_jump_i = 1'b0; bus.id_jump_target_i = '0;
        bus.ex_resolve_valid_i = 1'b0; bus.ex_resolve_pc_i = '0; bus.ex_taken_i = 1'b0;
        bus.ex_target_i = '0; bus.ex_pred_taken_i = 1'b0; bus.ex_pred_target_i = '0;
    endtask

    function automatic vec_t jmp(input logic [31:0] t);
        return '{1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, t, 1'b1, 1'b0};
    endfunction

    function automatic vec_t res(input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                                 input logic pt, input logic [31:0] ptgt, input logic [31:0] npc, input logic f);
        return '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rpc, tk, tgt, pt, ptgt, npc, f, f};
    endfunction

    function automatic vec_t idle_v(input logic [31:0] npc);
        return '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, npc, 1'b0, 1'b0};
    endfunction

    task automatic run(input string nm, input vec_t v);
        bus.stall_i = v.stall; bus.id_jr_i = v.jr; bus.id_jr_target_i = v.jrt;
        bus.id_jump_i = v.jump; bus.id_jump_target_i = v.jt;
        bus.ex_resolve_valid_i = v.rv; bus.ex_resolve_pc_i = v.rpc; bus.ex_taken_i = v.tk;
        bus.ex_target_i = v.tgt; bus.ex_pred_taken_i = v.pt; bus.ex_pred_target_i = v.ptgt;
        @(negedge clk);
        chk({nm, " flush_ifid"}, 32'(bus.flush_ifid_o), 32'(v.fi));
        chk({nm, " flush_idex"}, 32'(bus.flush_idex_o), 32'(v.fx));
        @(posedge clk);
        #1;
        chk({nm, " pc"}, bus.pc_o, v.pc);
        chk({nm, " pc_plus4"}, bus.pc_plus4_o, v.pc + 32'd4);
        if (v.rv) exp_br++;
        if (v.fx) exp_mp++;
        idle();
    endtask

    task automatic pred(input string nm, input logic t, input logic [31:0] tgt);
        #1;
        chk({nm, " pred_taken"}, 32'(bus.pred_taken_o), 32'(t));
        chk({nm, " pred_target"}, bus.pred_target_o, tgt);
    endtask

    initial begin
        //            stall jr    jrt           jump  jt            rv    rpc           tk    tgt       pt    ptgt      pc            fi    fx
        tbl[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h200,      1'b1, 32'h60,       1'b1, 32'h80, 1'b0, 32'h0,  32'h80,       1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 32'h300,     1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h300,      1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h400,      1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h300,      1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h60,       1'b0, 32'h0,  1'b1, 32'h80, 32'h64,       1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 32'h500,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h64,       1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h60,       1'b1, 32'h90, 1'b1, 32'h80, 32'h90,       1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h60,       1'b1, 32'h90, 1'b1, 32'h90, 32'h94,       1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'hFFFFFFFC, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h0,        1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,  1'b1, 32'h0,  32'h0,        1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h60,       1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h60,       1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h60,       1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h90,       1'b0, 1'b0};

        // reset held two cycles while a would-be mispredict is presented
        reset = 1'b1;
        idle();
        bus.ex_resolve_valid_i = 1'b1; bus.ex_taken_i = 1'b1;
        bus.ex_resolve_pc_i = 32'h10; bus.ex_target_i = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst flush_ifid", 32'(bus.flush_ifid_o), 32'h0);
        chk("rst flush_idex", 32'(bus.flush_idex_o), 32'h0);
        chk("rst pc", bus.pc_o, 32'h100);
        reset = 1'b0;
        idle();
        pred("rst", 1'b0, 32'h0);
        chk("post-rst pc", bus.pc_o, 32'h100);
        @(posedge clk); #1;
        chk("seq pc 104", bus.pc_o, 32'h104);
        @(posedge clk); #1;
        chk("seq pc 108", bus.pc_o, 32'h108);

        // cold taken branch allocates, then 0x10 predicts 0x40
        run("cold", res(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h40, 1'b1));
        run("jmp10a", jmp(32'h10));
        pred("cold", 1'b1, 32'h40);
        run("follow", idle_v(32'h40));

        // hysteresis and saturation at the bottom of the counter
        run("hyst", res(32'h10, 1'b0, 32'h0, 1'b1, 32'h40, 32'h14, 1'b1));
        run("jmp10b", jmp(32'h10));
        pred("hyst", 1'b0, 32'h40);
        run("nt1", res(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 32'h14, 1'b0));
        run("nt2", res(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 32'h18, 1'b0));
        run("tk_snt", res(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h40, 1'b1));
        run("jmp10c", jmp(32'h10));
        pred("sat_low", 1'b0, 32'h40);
        run("tk_wnt", res(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h40, 1'b1));
        run("jmp10d", jmp(32'h10));
        pred("wt", 1'b1, 32'h40);

        // same-cycle lookup/update: the fetch still follows the old WT state
        run("same_cycle", res(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0));
        run("jmp10e", jmp(32'h10));
        pred("after_update", 1'b0, 32'h40);

        for (int i = 0; i < 13; i++) run($sformatf("tbl[%0d]", i), tbl[i]);

        // aliasing on index 4: 0x10 and 0x50 evict each other
        run("jmp10f", jmp(32'h10));
        pred("alias pre", 1'b0, 32'h40);
        run("jmp50a", jmp(32'h50));
        pred("alias 50 miss", 1'b0, 32'h0);
        run("alloc50", res(32'h50, 1'b1, 32'hA0, 1'b0, 32'h0, 32'hA0, 1'b1));
        run("jmp10g", jmp(32'h10));
        pred("alias 10 evicted", 1'b0, 32'h0);
        run("jmp50b", jmp(32'h50));
        pred("alias 50 hit", 1'b1, 32'hA0);

`ifdef FETCH_PERF_EN
        chk("branch_cnt", bus.branch_cnt_o, 32'(exp_br));
        chk("mispred_cnt", bus.mispred_cnt_o, 32'(exp_mp));
`else
        chk("branch_cnt", bus.branch_cnt_o, 32'h0);
        chk("mispred_cnt", bus.mispred_cnt_o, 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
